// File: rtl/bru_notif_buffer.sv
// Elastic FIFO between the BRU branch-notification output and the ROB branch-notification input.
// Define BRU_NOTIF_BUFFER_PERF_EN to add saturating performance counter outputs.
module bru_notif_buffer #(
    parameter int DEPTH               = 4,
    parameter int LOG_DEPTH           = $clog2(DEPTH),
    // Defaults match core_types_pkg widths.
    parameter int LOG_ROB_ENTRIES     = 7,
    parameter int BTB_PRED_INFO_WIDTH = 8
) (
    input  logic                           CLK,
    input  logic                           nRST,

    input  logic                           in_valid,
    input  logic [LOG_ROB_ENTRIES-1:0]     in_ROB_index,
    input  logic                           in_is_mispredict,
    input  logic                           in_is_taken,
    input  logic                           in_is_out_of_range,
    input  logic [BTB_PRED_INFO_WIDTH-1:0] in_updated_pred_info,
    input  logic                           in_pred_lru,
    input  logic [31:0]                    in_start_PC,
    input  logic [31:0]                    in_target_PC,
    output logic                           in_ready,

    output logic                           out_valid,
    output logic [LOG_ROB_ENTRIES-1:0]     out_ROB_index,
    output logic                           out_is_mispredict,
    output logic                           out_is_taken,
    output logic                           out_is_out_of_range,
    output logic [BTB_PRED_INFO_WIDTH-1:0] out_updated_pred_info,
    output logic                           out_pred_lru,
    output logic [31:0]                    out_start_PC,
    output logic [31:0]                    out_target_PC,
    input  logic                           out_ready,

    input  logic                           flush_valid,
    output logic                           mispredict_pending,
    output logic [LOG_DEPTH:0]             occupancy
`ifdef BRU_NOTIF_BUFFER_PERF_EN
    ,
    output logic [31:0]                    perf_notif_count,
    output logic [31:0]                    perf_mispredict_count,
    output logic [31:0]                    perf_full_stall_cycles
`endif
);

    typedef struct packed {
        logic [LOG_ROB_ENTRIES-1:0]     rob_index;
        logic                           is_mispredict;
        logic                           is_taken;
        logic                           is_out_of_range;
        logic [BTB_PRED_INFO_WIDTH-1:0] updated_pred_info;
        logic                           pred_lru;
        logic [31:0]                    start_PC;
        logic [31:0]                    target_PC;
    } entry_t;

    localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH+1)'(DEPTH);

    entry_t               entries [DEPTH];
    entry_t               in_entry;
    entry_t               head_entry;
    logic [LOG_DEPTH-1:0] head;
    logic [LOG_DEPTH-1:0] tail;
    logic [LOG_DEPTH:0]   count;
    logic [LOG_DEPTH:0]   mispredict_count;
    logic                 enq;
    logic                 deq;
    logic                 enq_mispredict;
    logic                 deq_mispredict;

    assign in_entry = {in_ROB_index, in_is_mispredict, in_is_taken, in_is_out_of_range,
                       in_updated_pred_info, in_pred_lru, in_start_PC, in_target_PC};
    assign head_entry = entries[head];

    assign out_valid = (count != '0);
    // Full is still writable when the head leaves this cycle (out_ready -> in_ready path).
    assign in_ready  = (count < FULL_COUNT) || (out_valid && out_ready);

    assign enq            = in_valid && in_ready;
    assign deq            = out_valid && out_ready;
    assign enq_mispredict = enq && in_is_mispredict;
    assign deq_mispredict = deq && head_entry.is_mispredict;

    assign out_ROB_index         = head_entry.rob_index;
    assign out_is_mispredict     = head_entry.is_mispredict;
    assign out_is_taken          = head_entry.is_taken;
    assign out_is_out_of_range   = head_entry.is_out_of_range;
    assign out_updated_pred_info = head_entry.updated_pred_info;
    assign out_pred_lru          = head_entry.pred_lru;
    assign out_start_PC          = head_entry.start_PC;
    assign out_target_PC         = head_entry.target_PC;

    assign mispredict_pending = (mispredict_count != '0);
    assign occupancy          = count;

    // Storage needs no reset; pointers and count decide what is live.
    always_ff @(posedge CLK) begin
        if (enq) begin
            entries[tail] <= in_entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST || flush_valid) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            mispredict_count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + LOG_DEPTH'(1);
            end
            if (deq) begin
                head <= head + LOG_DEPTH'(1);
            end
            count            <= count + (LOG_DEPTH+1)'(enq) - (LOG_DEPTH+1)'(deq);
            mispredict_count <= mispredict_count + (LOG_DEPTH+1)'(enq_mispredict)
                                                 - (LOG_DEPTH+1)'(deq_mispredict);
        end
    end

`ifdef BRU_NOTIF_BUFFER_PERF_EN
    // Counters ignore flush, so enqueues later dropped by a flush are still counted.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            perf_notif_count       <= '0;
            perf_mispredict_count  <= '0;
            perf_full_stall_cycles <= '0;
        end else begin
            if (enq && (perf_notif_count != '1)) begin
                perf_notif_count <= perf_notif_count + 32'd1;
            end
            if (enq_mispredict && (perf_mispredict_count != '1)) begin
                perf_mispredict_count <= perf_mispredict_count + 32'd1;
            end
            if (in_valid && !in_ready && (perf_full_stall_cycles != '1)) begin
                perf_full_stall_cycles <= perf_full_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/bru_notif_buffer.md
Name: bru_notif_buffer

Overview:
- Elastic FIFO between the BRU pipeline's branch-notification output and the ROB branch-notification input.
- Decouples ROB backpressure from the BRU pipeline, so the BRU keeps issuing while the ROB is busy.
- Tracks whether any buffered notification is a mispredict (for front-end stall hints).
- Supports a full flush on ROB restart.

Parameters:
- DEPTH, 4, number of buffered notifications; power of 2, minimum 2.
- LOG_DEPTH, $clog2(DEPTH), pointer width.
- Widths LOG_ROB_ENTRIES and BTB_PRED_INFO_WIDTH come from core_types_pkg.

Ports:
- CLK  input  1  clock
- nRST  input  1  synchronous active-low reset, sampled on the rising edge of CLK
- in_valid  input  1  notification from the BRU pipeline is valid
- in_ROB_index  input  LOG_ROB_ENTRIES  ROB index of the branch
- in_is_mispredict  input  1  branch mispredicted
- in_is_taken  input  1  branch taken
- in_is_out_of_range  input  1  target out of BTB range
- in_updated_pred_info  input  BTB_PRED_INFO_WIDTH  updated prediction info
- in_pred_lru  input  1  prediction LRU bit
- in_start_PC  input  32  branch PC
- in_target_PC  input  32  resolved target PC
- in_ready  output  1  buffer accepts a notification this cycle
- out_valid  output  1  head notification valid toward the ROB
- out_ROB_index, out_is_mispredict, out_is_taken, out_is_out_of_range, out_updated_pred_info, out_pred_lru, out_start_PC, out_target_PC  output  same widths as the matching in_* ports  head entry fields
- out_ready  input  1  ROB accepts the head this cycle
- flush_valid  input  1  ROB restart; discard all entries
- mispredict_pending  output  1  at least one buffered entry has is_mispredict=1
- occupancy  output  LOG_DEPTH+1  number of buffered entries

Behaviour:
- Reset (nRST=0 at the clock edge):
  - count, head and tail pointers cleared to 0; storage not cleared.
  - Outputs after reset: out_valid=0, in_ready=1, mispredict_pending=0, occupancy=0. out_* data fields are don't-care while out_valid=0.
  - Reset mid-operation discards all entries immediately, regardless of any other input that cycle.
- Enqueue: fires when in_valid && in_ready. Writes the entry at the tail; tail advances modulo DEPTH.
- Dequeue: fires when out_valid && out_ready. Head advances modulo DEPTH.
- in_ready = (count < DEPTH) || (out_valid && out_ready).
  - Enqueue is allowed at full when a dequeue happens in the same cycle.
  - This creates a combinational path out_ready -> in_ready, which is permitted.
- out_valid = (count != 0). out_* are driven from registered storage at the head. There is no input-to-output bypass: minimum latency is 1 cycle from enqueue to out_valid.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This holds at count=DEPTH and at count=1 (at count=1 the new entry becomes the head next cycle).
- A dequeue request at empty is impossible because out_valid=0. An enqueue request at full without a dequeue gives in_ready=0 and the entry is not taken.
- Flush (flush_valid=1): next cycle count=0 and head=tail=0. Any same-cycle enqueue or dequeue is discarded. in_ready stays as computed; the handshake completes but the data is dropped. out_valid=0 the next cycle.
- Pointer wrap: pointers are LOG_DEPTH bits and wrap naturally; full and empty are distinguished by count.
- mispredict_pending: registered count of valid mispredict entries, compared against 0.
  - Increments on enqueue of a mispredict; decrements on dequeue of a mispredict; both in the same cycle leaves it unchanged.
  - Cleared on flush and on reset.
  - Reflects the buffer state after the previous edge, i.e. it is the registered count, not a lookahead.
- occupancy = count register.
- Entries are delivered in strict FIFO order. No reordering and no field modification.

Optional Feature:
- Macro: BRU_NOTIF_BUFFER_PERF_EN.
- When defined, three 32-bit output ports are added:
  - perf_notif_count: increments on each enqueue.
  - perf_mispredict_count: increments on each enqueue with in_is_mispredict=1.
  - perf_full_stall_cycles: increments each cycle with in_valid && !in_ready.
- Counter rules: all three reset to 0, saturate at 32'hFFFFFFFF, and are not affected by flush. Enqueues discarded by flush still count.
- When not defined, these ports and their logic are absent and the behaviour above is otherwise identical.

Test Plan:
- Reset, then in_valid=1 with ROB_index=5, target_PC=32'h0000_1000, out_ready=1 -> next cycle out_valid=1, out_ROB_index=5, out_target_PC=32'h0000_1000; the cycle after, out_valid=0 and occupancy=0.
- out_ready=0, enqueue ROB_index 1,2,3,4 on consecutive cycles -> occupancy=4, in_ready=0. A 5th in_valid is not accepted. Then raise out_ready -> outputs 1,2,3,4 in order.
- At full, in_valid=1 (ROB_index=9) with out_ready=1 -> same-cycle enqueue and dequeue, occupancy stays 4, entry 9 emerges last. Run 10 such cycles to exercise pointer wrap.
- Enqueue mispredict entries with ROB_index 7 and 8 -> mispredict_pending=1. Dequeue 7 -> still 1. Dequeue 8 -> 0. Same-cycle enqueue and dequeue of two mispredicts -> stays 1.
- With occupancy=3, assert flush_valid together with in_valid and out_ready -> next cycle occupancy=0, out_valid=0, mispredict_pending=0. The flushed data never appears.
- Drive nRST=0 for one edge while occupancy=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, occupancy=0. With PERF_EN defined, all three counters read 0.
